fetch_stage: RTL and testbench

- Instruction fetch stage directly downstream of the 8-bit program counter.
- Consumes the PC value and issues a req/ack read to instruction memory.
- Buffers returned instructions, tagged with their address, in a small FIFO toward decode.
- Drives the PC's hold and increment-base inputs so the PC advances only when a fetch completes; on a taken jump it flushes and lets the PC load the jump target.

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// fetch_stage: issues req/ack instruction reads at the PC address, buffers tagged results
// in a small FIFO toward decode, and gates PC advance through hold.
module fetch_stage #(
   parameter int ADDR_W    = 8,
   parameter int INSTR_W   = 16,
   parameter int BUF_DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pcIn,
   output logic [ADDR_W-1:0]  pcFeedback,
   output logic               hold,
   input  logic               flush,
   output logic               memReq,
   output logic [ADDR_W-1:0]  memAddr,
   input  logic               memAck,
   input  logic [INSTR_W-1:0] memData,
   output logic [INSTR_W-1:0] instrOut,
   output logic [ADDR_W-1:0]  instrPC,
   output logic               instrValid,
   input  logic               instrReady
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [INSTR_W-1:0] buf_instr [BUF_DEPTH];
   logic [ADDR_W-1:0]  buf_pc    [BUF_DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr, head_idx;
   logic [CNT_W-1:0]   count, count_nxt;
   logic               issue, push, pop;
   logic [INSTR_W-1:0] head_instr_nxt;
   logic [ADDR_W-1:0]  head_pc_nxt;

   assign pcFeedback = pcIn;
   assign instrValid = (count != '0);
   assign hold       = ~(flush | ((state == WAIT) & memAck));
   assign push       = (state == WAIT) & memAck & ~flush;
   assign pop        = instrValid & instrReady & ~flush;

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (!flush && count < DEPTH_C) begin
               state_nxt = WAIT;
               issue     = 1'b1;
            end
         end
         WAIT: begin
            if (memAck)
               state_nxt = IDLE;
            else if (flush)
               state_nxt = DROP;
         end
         DROP: begin
            if (memAck)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Head after this edge: a write landing on the new head slot must bypass the array.
   always_comb begin
      head_idx = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
      if (push && wr_ptr == head_idx) begin
         head_instr_nxt = memData;
         head_pc_nxt    = memAddr;
      end else begin
         head_instr_nxt = buf_instr[head_idx];
         head_pc_nxt    = buf_pc[head_idx];
      end
      count_nxt = count;
      if (flush)
         count_nxt = '0;
      else if (push && !pop)
         count_nxt = count + CNT_W'(1);
      else if (pop && !push)
         count_nxt = count - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         memReq   <= 1'b0;
         memAddr  <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         instrOut <= '0;
         instrPC  <= '0;
      end else begin
         state  <= state_nxt;
         memReq <= (state_nxt != IDLE);
         if (issue)
            memAddr <= pcIn;
         count <= count_nxt;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
            if (push)
               wr_ptr <= wr_ptr + PTR_W'(1);
         end
         // Outputs keep their last value once the buffer drains.
         if (count_nxt != '0) begin
            instrOut <= head_instr_nxt;
            instrPC  <= head_pc_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr[wr_ptr] <= memData;
         buf_pc[wr_ptr]    <= memAddr;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// tb_fetch_stage: table vectors, directed corner sequences and random traffic
// checked against a queue-based reference model of the fetch stage.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  pcIn = '0;
   logic [7:0]  pcFeedback;
   logic        hold;
   logic        flush = 1'b0;
   logic        memReq;
   logic [7:0]  memAddr;
   logic        memAck = 1'b0;
   logic [15:0] memData = '0;
   logic [15:0] instrOut;
   logic [7:0]  instrPC;
   logic        instrValid;
   logic        instrReady = 1'b0;

   fetch_stage #(.ADDR_W(8), .INSTR_W(16), .BUF_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .pcIn(pcIn), .pcFeedback(pcFeedback), .hold(hold),
      .flush(flush), .memReq(memReq), .memAddr(memAddr), .memAck(memAck),
      .memData(memData), .instrOut(instrOut), .instrPC(instrPC),
      .instrValid(instrValid), .instrReady(instrReady)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: request bookkeeping plus a queue standing in for the buffer.
   typedef struct packed { logic [15:0] instr; logic [7:0] pc; } entry_t;
   entry_t     q[$];
   bit         m_busy, m_drop;
   logic [7:0] m_addr;
   logic [15:0] m_last_i;
   logic [7:0]  m_last_pc;
   logic        exp_hold;
   logic [7:0]  pc;

   typedef struct {
      logic rst; logic [7:0] pc; logic fl; logic ack; logic [15:0] data; logic rdy;
      logic e_req; logic [7:0] e_addr; logic e_hold; logic e_valid;
      logic [15:0] e_instr; logic [7:0] e_ipc;
   } vec_t;
   vec_t tbl[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_busy = 0; m_drop = 0; m_addr = '0; m_last_i = '0; m_last_pc = '0;
   endtask

   task automatic model_update();
      bit pop_m, push_m;
      pop_m  = (q.size() > 0) && instrReady && !flush;
      push_m = 0;
      if (m_busy) begin
         if (memAck) begin
            push_m = !m_drop && !flush;
            m_busy = 0;
         end else if (flush) begin
            m_drop = 1;
         end
      end else if (!flush && q.size() < 2) begin
         m_busy = 1; m_drop = 0; m_addr = pcIn;
      end
      if (flush) q.delete();
      else begin
         if (pop_m) void'(q.pop_front());
         if (push_m) q.push_back({memData, m_addr});
      end
      if (q.size() > 0) begin
         m_last_i = q[0].instr; m_last_pc = q[0].pc;
      end
   endtask

   task automatic drive(input logic r, input logic [7:0] p, input logic f, input logic a,
                        input logic [15:0] d, input logic rdy);
      @(negedge clk);
      reset = r; pcIn = p; flush = f; memAck = a; memData = d; instrReady = rdy;
      if (r) model_reset();
      #1;
      exp_hold = !(f || (m_busy && !m_drop && a));
      chk("memReq",     memReq,     m_busy);
      chk("memAddr",    memAddr,    m_addr);
      chk("hold",       hold,       exp_hold);
      chk("pcFeedback", pcFeedback, p);
      chk("instrValid", instrValid, q.size() > 0);
      chk("instrOut",   instrOut,   q.size() > 0 ? q[0].instr : m_last_i);
      chk("instrPC",    instrPC,    q.size() > 0 ? q[0].pc : m_last_pc);
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else model_update();
   endtask

   // One cycle with an external PC that follows hold/flush like the real PC.
   task automatic cyc(input logic f, input logic a, input logic [15:0] d,
                      input logic rdy, input logic [7:0] tgt);
      drive(1'b0, pc, f, a, d, rdy);
      tick();
      pc = f ? tgt : (exp_hold ? pc : pc + 8'd1);
   endtask

   task automatic do_reset();
      drive(1'b1, pc, 1'b0, 1'b0, 16'h0, 1'b0);
      tick();
   endtask

   logic        r_r, r_f, r_a, r_rdy;
   logic [15:0] r_d;
   logic [7:0]  r_t;

   initial begin
      // rst pc fl ack data rdy | req addr hold valid instr ipc
      tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 16'hA000, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00};
      tbl[3]  = '{1'b0, 8'h01, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 16'hA000, 8'h00};
      tbl[4]  = '{1'b0, 8'h01, 1'b0, 1'b1, 16'hA001, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 16'hA000, 8'h00};
      tbl[5]  = '{1'b0, 8'h02, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 16'hA001, 8'h01};
      tbl[6]  = '{1'b0, 8'h02, 1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 16'hA001, 8'h01};
      tbl[7]  = '{1'b0, 8'h40, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 16'hA001, 8'h01};
      tbl[8]  = '{1'b0, 8'h40, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 16'hA001, 8'h01};
      tbl[9]  = '{1'b0, 8'h40, 1'b0, 1'b1, 16'h4040, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0, 16'hA001, 8'h01};
      tbl[10] = '{1'b0, 8'h41, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h40, 1'b1, 1'b1, 16'h4040, 8'h40};

      model_reset();
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].rst, tbl[i].pc, tbl[i].fl, tbl[i].ack, tbl[i].data, tbl[i].rdy);
         chk("tbl_memReq",     memReq,     tbl[i].e_req);
         chk("tbl_memAddr",    memAddr,    tbl[i].e_addr);
         chk("tbl_hold",       hold,       tbl[i].e_hold);
         chk("tbl_instrValid", instrValid, tbl[i].e_valid);
         chk("tbl_instrOut",   instrOut,   tbl[i].e_instr);
         chk("tbl_instrPC",    instrPC,    tbl[i].e_ipc);
         tick();
      end

      // Decode stalled: buffer fills with 00 and 01, then a pop frees room for 02.
      pc = 8'h00;
      do_reset();
      for (int i = 0; i < 10; i++) cyc(1'b0, m_busy, 16'hB000 | 16'(pc), 1'b0, 8'h00);
      drive(1'b0, pc, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("full_noreq", memReq, 1'b0);
      chk("full_hold",  hold,   1'b1);
      chk("full_head",  instrPC, 8'h00);
      tick();
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 8'h00);
      cyc(1'b0, 1'b0, 16'h0, 1'b0, 8'h00);
      drive(1'b0, pc, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("refill_addr", memAddr, 8'h02);
      chk("refill_req",  memReq,  1'b1);
      tick();

      // Flush while waiting, ack arrives 3 cycles later and is dropped.
      pc = 8'h10;
      do_reset();
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 8'h00);
      drive(1'b0, pc, 1'b1, 1'b0, 16'h0, 1'b1);
      chk("flush_hold", hold, 1'b0);
      tick();
      pc = 8'h80;
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 16'h0, 1'b1, 8'h00);
      drive(1'b0, pc, 1'b0, 1'b1, 16'hBAD0, 1'b1);
      chk("drop_req",  memReq, 1'b1);
      chk("drop_hold", hold,   1'b1);
      tick();
      drive(1'b0, pc, 1'b0, 1'b0, 16'h0, 1'b1);
      chk("drop_empty", instrValid, 1'b0);
      tick();
      drive(1'b0, pc, 1'b0, 1'b0, 16'h0, 1'b1);
      chk("jump_addr", memAddr, 8'h80);
      tick();

      // Reset during WAIT, then a late ack that must be ignored.
      pc = 8'h33;
      do_reset();
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 8'h00);
      drive(1'b1, pc, 1'b0, 1'b0, 16'h0, 1'b1);
      chk("rst_req",  memReq,  1'b0);
      chk("rst_addr", memAddr, 8'h00);
      tick();
      drive(1'b0, pc, 1'b0, 1'b1, 16'hCAFE, 1'b1);
      chk("late_ack_hold", hold, 1'b1);
      tick();
      drive(1'b0, pc, 1'b0, 1'b0, 16'h0, 1'b1);
      chk("late_ack_valid", instrValid, 1'b0);
      chk("restart_addr",   memAddr,    8'h33);
      tick();

      // Random traffic, including PC wrap, flushes, stalls and rare resets.
      for (int i = 0; i < 2000; i++) begin
         r_r   = ($urandom_range(0, 249) == 0);
         r_f   = ($urandom_range(0, 7) == 0);
         r_a   = $urandom_range(0, 1) != 0;
         r_rdy = $urandom_range(0, 2) != 0;
         r_d   = 16'($urandom);
         r_t   = 8'($urandom);
         if (r_r) do_reset();
         else cyc(r_f, r_a, r_d, r_rdy, r_t);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
